// File: rtl/keypad_pkg.sv
// Shared key codes, phase encoding and power-of-ten helper for the keypad operand-entry block.
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_DEL   = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;

    // Digit count never exceeds 4, so three bits always suffice.
    localparam int COUNT_W = 3;

    typedef enum logic [1:0] {
        PH_ENTRY_A  = 2'd0,
        PH_ENTRY_B  = 2'd1,
        PH_WAIT_DIV = 2'd2,
        PH_RESULT   = 2'd3
    } phase_t;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/dec_digit_buffer.sv
// Right-aligned BCD digit store with append/delete/clear, plus its binary value and echo.
module dec_digit_buffer
    import keypad_pkg::*;
#(
    parameter int W          = 7,
    parameter int MAX_DIGITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         digit,
    input  logic               append,
    input  logic               del,
    input  logic               clr,
    output logic [COUNT_W-1:0] count,
    output logic [W-1:0]       value,
    output logic [15:0]        echo
);

    logic [3:0] digits [MAX_DIGITS];

    // clr together with append loads the new digit as the only digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                digits[i] <= '0;
            end
            count <= '0;
        end else if (clr) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                digits[i] <= '0;
            end
            if (append) begin
                digits[0] <= digit;
                count     <= COUNT_W'(1);
            end else begin
                count <= '0;
            end
        end else if (append) begin
            if (count < COUNT_W'(MAX_DIGITS)) begin
                for (int i = MAX_DIGITS - 1; i > 0; i--) begin
                    digits[i] <= digits[i-1];
                end
                digits[0] <= digit;
                count     <= count + 1'b1;
            end
        end else if (del) begin
            if (count != '0) begin
                for (int i = 0; i < MAX_DIGITS - 1; i++) begin
                    digits[i] <= digits[i+1];
                end
                digits[MAX_DIGITS-1] <= '0;
                count                <= count - 1'b1;
            end
        end
    end

    // Unused digit slots are always zero, so the sums and echo need no masking.
    always_comb begin
        value = '0;
        echo  = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            value = value + W'(digits[i]) * W'(pow10(i));
            echo[4*i +: 4] = digits[i];
        end
    end

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand-entry controller feeding the restoring divider.
// Optional macro ZERO_DIV_CHECK_EN rejects a zero divisor with an err pulse.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int W          = 7,
    parameter int MAX_DIGITS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   key,
    input  logic         key_valid,
    input  logic         div_done,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic         div_start,
    output logic         busy,
    output logic [1:0]   phase,
    output logic [15:0]  echo_bcd,
    output logic         err
);

    // state       | meaning
    // ENTRY_A     | typing dividend A
    // ENTRY_B     | typing divisor B, A latched
    // WAIT_DIV    | division outstanding, keys ignored
    // RESULT      | division finished, waiting for next entry
    localparam logic [1:0] ST_ENTRY_A  = PH_ENTRY_A;
    localparam logic [1:0] ST_ENTRY_B  = PH_ENTRY_B;
    localparam logic [1:0] ST_WAIT_DIV = PH_WAIT_DIV;
    localparam logic [1:0] ST_RESULT   = PH_RESULT;

    logic [1:0]         phase_q, phase_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;

    logic               buf_append, buf_del, buf_clr;
    logic [COUNT_W-1:0] count;
    logic [W-1:0]       value;
    logic               is_digit;
    logic               has_digits;

`ifdef ZERO_DIV_CHECK_EN
    logic               reject;
    logic               err_q;
`endif

    dec_digit_buffer #(
        .W          (W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_digits (
        .clk    (clk),
        .rst    (rst),
        .digit  (key),
        .append (buf_append),
        .del    (buf_del),
        .clr    (buf_clr),
        .count  (count),
        .value  (value),
        .echo   (echo_bcd)
    );

    assign is_digit   = (key <= 4'd9);
    assign has_digits = (count != '0);

    always_comb begin
        phase_d    = phase_q;
        a_d        = a_q;
        b_d        = b_q;
        start_d    = 1'b0;
        busy_d     = busy_q;
        buf_append = 1'b0;
        buf_del    = 1'b0;
        buf_clr    = 1'b0;
`ifdef ZERO_DIV_CHECK_EN
        reject     = 1'b0;
`endif
        case (phase_q)
            ST_ENTRY_A: begin
                if (key_valid) begin
                    if (is_digit) begin
                        buf_append = 1'b1;
                    end else if (key == KEY_DEL) begin
                        buf_del = 1'b1;
                    end else if (key == KEY_CLR) begin
                        buf_clr = 1'b1;
                    end else if (key == KEY_ENTER && has_digits) begin
                        a_d     = value;
                        buf_clr = 1'b1;
                        phase_d = ST_ENTRY_B;
                    end
                end
            end
            ST_ENTRY_B: begin
                if (key_valid) begin
                    if (is_digit) begin
                        buf_append = 1'b1;
                    end else if (key == KEY_DEL) begin
                        buf_del = 1'b1;
                    end else if (key == KEY_CLR) begin
                        buf_clr = 1'b1;
                        a_d     = '0;
                        phase_d = ST_ENTRY_A;
                    end else if (key == KEY_ENTER && has_digits) begin
                        buf_clr = 1'b1;
`ifdef ZERO_DIV_CHECK_EN
                        if (value == '0) begin
                            reject = 1'b1;
                        end else
`endif
                        begin
                            b_d     = value;
                            start_d = 1'b1;
                            busy_d  = 1'b1;
                            phase_d = ST_WAIT_DIV;
                        end
                    end
                end
            end
            ST_WAIT_DIV: begin
                // Keys arriving with done are dropped; only done matters here.
                if (div_done) begin
                    busy_d  = 1'b0;
                    phase_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (key_valid) begin
                    if (is_digit) begin
                        buf_clr    = 1'b1;
                        buf_append = 1'b1;
                        phase_d    = ST_ENTRY_A;
                    end else if (key == KEY_CLR) begin
                        buf_clr = 1'b1;
                        phase_d = ST_ENTRY_A;
                    end
                end
            end
            default: begin
                phase_d = ST_ENTRY_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= ST_ENTRY_A;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ZERO_DIV_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= reject;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign phase     = phase_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign div_start = start_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed vector bench for keypad_operand_entry (W=7, MAX_DIGITS=2).
module tb_keypad_operand_entry;

    logic        clk;
    logic        rst;
    logic [3:0]  key;
    logic        key_valid;
    logic        div_done;
    logic [6:0]  a_out;
    logic [6:0]  b_out;
    logic        div_start;
    logic        busy;
    logic [1:0]  phase;
    logic [15:0] echo_bcd;
    logic        err;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [3:0]  key;
        logic        kv;
        logic        dd;
        logic [1:0]  ph;
        logic [6:0]  a;
        logic [6:0]  b;
        logic        st;
        logic        bz;
        logic [15:0] echo;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    keypad_operand_entry #(.W(7), .MAX_DIGITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .key_valid (key_valid),
        .div_done  (div_done),
        .a_out     (a_out),
        .b_out     (b_out),
        .div_start (div_start),
        .busy      (busy),
        .phase     (phase),
        .echo_bcd  (echo_bcd),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check("phase", idx, 16'(phase), 16'(v.ph));
        check("a_out", idx, 16'(a_out), 16'(v.a));
        check("b_out", idx, 16'(b_out), 16'(v.b));
        check("div_start", idx, 16'(div_start), 16'(v.st));
        check("busy", idx, 16'(busy), 16'(v.bz));
        check("echo_bcd", idx, echo_bcd, v.echo);
        check("err", idx, 16'(err), 16'(v.er));
    endtask

    function automatic void add(input logic [3:0] k, input logic kv, input logic dd,
                                input logic [1:0] ph, input logic [6:0] a, input logic [6:0] b,
                                input logic st, input logic bz, input logic [15:0] echo,
                                input logic er);
        vec_t v;
        v.key = k; v.kv = kv; v.dd = dd; v.ph = ph; v.a = a; v.b = b;
        v.st = st; v.bz = bz; v.echo = echo; v.er = er;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        key       = v.key;
        key_valid = v.kv;
        div_done  = v.dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        key       = 4'h0;
        key_valid = 1'b0;
        div_done  = 1'b0;

        //   key    kv dd  ph  a      b     st bz echo     er
        add(4'h4, 1, 0, 0, 7'd0,  7'd0, 0, 0, 16'h0004, 0);
        add(4'h2, 1, 0, 0, 7'd0,  7'd0, 0, 0, 16'h0042, 0);
        add(4'hA, 1, 0, 1, 7'd42, 7'd0, 0, 0, 16'h0000, 0);
        add(4'h5, 1, 0, 1, 7'd42, 7'd0, 0, 0, 16'h0005, 0);
        add(4'hA, 1, 0, 2, 7'd42, 7'd5, 1, 1, 16'h0000, 0);
        add(4'h0, 0, 0, 2, 7'd42, 7'd5, 0, 1, 16'h0000, 0);
        add(4'h0, 0, 1, 3, 7'd42, 7'd5, 0, 0, 16'h0000, 0);
        add(4'hC, 1, 0, 0, 7'd42, 7'd5, 0, 0, 16'h0000, 0);
        add(4'hA, 1, 0, 0, 7'd42, 7'd5, 0, 0, 16'h0000, 0);  // empty ENTER in A
        add(4'h1, 1, 0, 0, 7'd42, 7'd5, 0, 0, 16'h0001, 0);
        add(4'h2, 1, 0, 0, 7'd42, 7'd5, 0, 0, 16'h0012, 0);
        add(4'h3, 1, 0, 0, 7'd42, 7'd5, 0, 0, 16'h0012, 0);  // third digit dropped
        add(4'hA, 1, 0, 1, 7'd12, 7'd5, 0, 0, 16'h0000, 0);
        add(4'hC, 1, 0, 0, 7'd0,  7'd5, 0, 0, 16'h0000, 0);  // CLR in B clears A
        add(4'h9, 1, 0, 0, 7'd0,  7'd5, 0, 0, 16'h0009, 0);
        add(4'h8, 1, 0, 0, 7'd0,  7'd5, 0, 0, 16'h0098, 0);
        add(4'hB, 1, 0, 0, 7'd0,  7'd5, 0, 0, 16'h0009, 0);
        add(4'h7, 1, 0, 0, 7'd0,  7'd5, 0, 0, 16'h0097, 0);
        add(4'hA, 1, 0, 1, 7'd97, 7'd5, 0, 0, 16'h0000, 0);
        add(4'hA, 1, 0, 1, 7'd97, 7'd5, 0, 0, 16'h0000, 0);  // empty ENTER in B
        add(4'hB, 1, 0, 1, 7'd97, 7'd5, 0, 0, 16'h0000, 0);
        add(4'hD, 1, 0, 1, 7'd97, 7'd5, 0, 0, 16'h0000, 0);
        add(4'h0, 0, 1, 1, 7'd97, 7'd5, 0, 0, 16'h0000, 0);  // stray done
        add(4'h6, 1, 0, 1, 7'd97, 7'd5, 0, 0, 16'h0006, 0);
        add(4'hB, 1, 0, 1, 7'd97, 7'd5, 0, 0, 16'h0000, 0);
        add(4'h3, 1, 0, 1, 7'd97, 7'd5, 0, 0, 16'h0003, 0);
        add(4'hA, 1, 0, 2, 7'd97, 7'd3, 1, 1, 16'h0000, 0);
        add(4'h3, 1, 0, 2, 7'd97, 7'd3, 0, 1, 16'h0000, 0);
        add(4'hC, 1, 0, 2, 7'd97, 7'd3, 0, 1, 16'h0000, 0);
        add(4'h7, 1, 1, 3, 7'd97, 7'd3, 0, 0, 16'h0000, 0);  // key dropped, done taken
        add(4'h0, 0, 1, 3, 7'd97, 7'd3, 0, 0, 16'h0000, 0);
        add(4'hA, 1, 0, 3, 7'd97, 7'd3, 0, 0, 16'h0000, 0);
        add(4'h5, 1, 0, 0, 7'd97, 7'd3, 0, 0, 16'h0005, 0);
        add(4'hA, 1, 0, 1, 7'd5,  7'd3, 0, 0, 16'h0000, 0);
        add(4'h0, 1, 0, 1, 7'd5,  7'd3, 0, 0, 16'h0000, 0);
`ifdef ZERO_DIV_CHECK_EN
        add(4'hA, 1, 0, 1, 7'd5,  7'd3, 0, 0, 16'h0000, 1);
        add(4'h0, 0, 0, 1, 7'd5,  7'd3, 0, 0, 16'h0000, 0);
`else
        add(4'hA, 1, 0, 2, 7'd5,  7'd0, 1, 1, 16'h0000, 0);
        add(4'h0, 0, 1, 3, 7'd5,  7'd0, 0, 0, 16'h0000, 0);
`endif

        #12;
        idle = '{key: 4'h0, kv: 1'b0, dd: 1'b0, ph: 2'd0, a: 7'd0, b: 7'd0,
                 st: 1'b0, bz: 1'b0, echo: 16'h0000, er: 1'b0};
        check_all(-1, idle);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check_all(i, vecs[i]);
        end

        // Reset in the middle of a division, then a late done.
        apply('{key: 4'h1, kv: 1'b1, dd: 1'b0, ph: 2'd0, a: 7'd0, b: 7'd0,
                st: 1'b0, bz: 1'b0, echo: 16'h0, er: 1'b0});
        apply('{key: 4'hC, kv: 1'b1, dd: 1'b0, ph: 2'd0, a: 7'd0, b: 7'd0,
                st: 1'b0, bz: 1'b0, echo: 16'h0, er: 1'b0});
        apply('{key: 4'h8, kv: 1'b1, dd: 1'b0, ph: 2'd0, a: 7'd0, b: 7'd0,
                st: 1'b0, bz: 1'b0, echo: 16'h0, er: 1'b0});
        apply('{key: 4'hA, kv: 1'b1, dd: 1'b0, ph: 2'd0, a: 7'd0, b: 7'd0,
                st: 1'b0, bz: 1'b0, echo: 16'h0, er: 1'b0});
        apply('{key: 4'h2, kv: 1'b1, dd: 1'b0, ph: 2'd0, a: 7'd0, b: 7'd0,
                st: 1'b0, bz: 1'b0, echo: 16'h0, er: 1'b0});
        apply('{key: 4'hA, kv: 1'b1, dd: 1'b0, ph: 2'd0, a: 7'd0, b: 7'd0,
                st: 1'b0, bz: 1'b0, echo: 16'h0, er: 1'b0});
        check("pre_reset_phase", 100, 16'(phase), 16'd2);
        check("pre_reset_a", 100, 16'(a_out), 16'd8);
        check("pre_reset_b", 100, 16'(b_out), 16'd2);
        check("pre_reset_busy", 100, 16'(busy), 16'd1);
        @(negedge clk);
        key_valid = 1'b0;
        rst       = 1'b0;
        #1;
        check_all(101, idle);
        @(negedge clk);
        rst = 1'b1;
        apply('{key: 4'h0, kv: 1'b0, dd: 1'b1, ph: 2'd0, a: 7'd0, b: 7'd0,
                st: 1'b0, bz: 1'b0, echo: 16'h0, er: 1'b0});
        check_all(102, idle);
        apply(idle);
        check_all(103, idle);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_operand_entry.md
# keypad_operand_entry

Decimal operand-entry controller between the debounced keypad scanner and the restoring divider. It turns one-cycle key pulses into two decimal operands, dividend A then divisor B, with digit, backspace, clear and enter keys. It issues a single start pulse to the divider and holds the operands stable until the divider reports done. It also provides a BCD echo of the operand being typed for the 7-segment mux.

## Interface
- W, default 7: operand width in bits.
- MAX_DIGITS, default 2: decimal digits per operand. Constraint: 10^MAX_DIGITS−1 ≤ 2^W−1 and MAX_DIGITS ≤ 4.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- key  in  4  hex key code from the scanner
- key_valid  in  1  one-cycle pulse; key is valid this cycle
- div_done  in  1  one-cycle pulse from the divider
- a_out  out  W  dividend to the divider
- b_out  out  W  divisor to the divider
- div_start  out  1  one-cycle start pulse to the divider
- busy  out  1  high while a division is outstanding
- phase  out  2  0 = ENTRY_A, 1 = ENTRY_B, 2 = WAIT_DIV, 3 = RESULT
- echo_bcd  out  16  BCD digits of the current entry; digit 0 is in [3:0]; unused nibbles are 0
- err  out  1  one-cycle pulse when an enter key is rejected

## Operation
- Key map:
  - 0x0–0x9: digit
  - 0xA: ENTER
  - 0xB: DEL
  - 0xC: CLR
  - 0xD–0xF: ignored
- State machine:
  - ENTRY_A
    - Digit: appended if count < MAX_DIGITS, otherwise dropped.
    - DEL: removes the last digit; no effect when empty.
    - ENTER with count > 0: latches the value into a_out, clears the digits, goes to ENTRY_B.
    - ENTER with count = 0: ignored.
    - CLR: clears the digits.
  - ENTRY_B
    - Digit and DEL behave as in ENTRY_A.
    - CLR: clears the digits, clears a_out to 0, goes to ENTRY_A.
    - ENTER with count > 0: latches b_out, pulses div_start, goes to WAIT_DIV. The ZERO_DIV_CHECK_EN exception is described under Configuration.
  - WAIT_DIV
    - All keys are ignored.
    - div_done: goes to RESULT.
  - RESULT
    - Digit: clears the digits, goes to ENTRY_A with that digit as the first digit.
    - CLR: goes to ENTRY_A with the digits empty.
    - Other keys: ignored.
- Arithmetic: value = Σ digit_i·10^i, computed from the stored BCD digits; there is no running multiply and no overflow by construction.
- echo_bcd shows the stored digits, right-aligned. It is 0 when the digit count is 0.
- a_out and b_out change only on an accepted ENTER, on CLR in ENTRY_B (a_out only), or on reset.
- div_done outside WAIT_DIV is ignored.

## Timing
- All outputs are registered. The effect of key_valid in cycle N is visible in cycle N+1.
- Accepted ENTER in ENTRY_B at cycle N:
  - div_start is high in cycle N+1 only.
  - a_out and b_out are valid from cycle N+1.
  - busy rises in N+1.
- div_done at cycle M: busy is low and phase is 3 from cycle M+1.
- key_valid and div_done in the same cycle in WAIT_DIV: the key is dropped and done is honoured.
- Reset values:
  - phase = 0
  - a_out, b_out, echo_bcd = 0
  - div_start, busy, err = 0
  - digit count = 0
- Reset mid-WAIT_DIV returns to ENTRY_A. A later div_done is ignored.

## Configuration
- ZERO_DIV_CHECK_EN defined: ENTER in ENTRY_B with value 0 is rejected.
  - err pulses in cycle N+1.
  - The digits are cleared.
  - The block stays in ENTRY_B.
  - No div_start, and b_out is unchanged.
- ZERO_DIV_CHECK_EN undefined:
  - A value of 0 is accepted like any other.
  - err is tied to 0.

## Structure
- keypad_pkg holds:
  - key code constants: KEY_ENTER, KEY_DEL, KEY_CLR
  - the phase enum, logic [1:0]
  - the power-of-ten constant function
- Sub-module dec_digit_buffer holds:
  - the BCD digit shift register and count
  - append, delete and clear operations
  - the combinational binary value and echo outputs
- keypad_operand_entry contains the FSM and the output registers.

## Test plan
- Keys 4, 2, ENTER, 5, ENTER → one-cycle div_start; a_out = 42, b_out = 5, busy = 1, phase = 2. Then div_done → busy = 0, phase = 3.
- Keys 1, 2, 3 → echo_bcd = 0x0012, because the third digit is dropped. Then ENTER → a_out = 12.
- Keys 9, 8, DEL, 7, ENTER → a_out = 97. ENTER with no digits in ENTRY_B → no state change.
- Keys 6, ENTER, 0, ENTER:
  - With ZERO_DIV_CHECK_EN: err pulse, phase = 1, echo_bcd = 0, no div_start.
  - Without ZERO_DIV_CHECK_EN: div_start with b_out = 0.
- In WAIT_DIV, press 3 and CLR → ignored. Assert key_valid and div_done together → phase = 3. Then digit 5 → phase = 0, echo_bcd = 0x0005.
- Assert rst during WAIT_DIV → all outputs 0, phase = 0. Subsequent div_done → no change.
